// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, frame constants
// and a small parity helper. Optional parity is selected with UART_TX_PARITY_EN.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO for the UART transmitter: power-of-two depth, wrapping
// pointers, occupancy count, asynchronous active-high reset.
module uart_byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [7:0]                    i_wr_data,
    output logic [7:0]                    o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign o_full    = (count_q == DEPTH_C);
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_rd_data = mem[rd_ptr_q];

    // Pointers wrap for free because the depth is a power of two.
    always_comb begin
        push_ok  = i_push && !o_full;
        pop_ok   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO, LSB-first
// serialiser. Define UART_TX_PARITY_EN to insert an even parity bit before STOP.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [2:0]                    o_state
);

    // Handshake: a byte transfers on a rising edge where i_valid && o_ready;
    // i_data must be stable while i_valid is high, and o_ready never depends on i_valid.

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic       fifo_push, fifo_pop;
    logic [7:0] fifo_rd_data;
    logic       fifo_full, fifo_empty;
    logic       baud_last;

    assign o_ready   = !fifo_full;
    assign fifo_push = i_valid && !fifo_full;
    assign o_tx      = tx_q;
    assign o_busy    = (state_q != S_IDLE) || !fifo_empty;
    assign o_state   = state_q;
    assign baud_last = (baud_q == BAUD_LAST);

    uart_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_push    (fifo_push),
        .i_pop     (fifo_pop),
        .i_wr_data (i_data),
        .o_rd_data (fifo_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (o_fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    baud_d   = '0;
                    state_d  = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_rd_data);
`endif
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_rd_data);
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // The line register follows the next state so o_tx changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: cycle-level line model plus frame decoder and byte
// scoreboard; honours UART_TX_PARITY_EN for the parity frame format.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [7:0]    i_data;
    logic          i_valid;
    logic          o_ready;
    logic          o_tx;
    logic          o_busy;
    logic [CW-1:0] o_fifo_count;
    logic [2:0]    o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued bytes, and the per-cycle line values still to appear.
    logic [7:0] m_fifo[$];
    logic       m_line[$];
    logic       m_on_line;
    logic       m_tx;
    logic       last_acc;

    // Scoreboard of accepted bytes, drained by the frame decoder.
    logic [7:0] exp_q[$];
    logic       dec_buf[$];
    logic       dec_active;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_fifo_count (o_fifo_count),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_line.delete();
        m_on_line  = 1'b0;
        m_tx       = 1'b1;
        last_acc   = 1'b0;
        exp_q.delete();
        dec_buf.delete();
        dec_active = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < CPB; r++) m_line.push_back(bits[k]);
        end
    endtask

    task automatic decode_frame();
        logic [7:0] db;
        for (int i = 0; i < 8; i++) db[i] = dec_buf[CPB * (1 + i) + CPB / 2];
        check("stop_bit", 32'(dec_buf[FRAME - CPB + CPB / 2]), 32'd1);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", 32'(dec_buf[9 * CPB + CPB / 2]), 32'(^db));
`endif
        if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", 32'(db), 32'hFFFF_FFFF);
        end else begin
            check("sb_byte", 32'(db), 32'(exp_q.pop_front()));
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
    task automatic step();
        logic       acc;
        logic       pop_now;
        logic [7:0] b;
        @(posedge clk);
        if (i_reset) begin
            model_reset();
        end else begin
            pop_now = (m_line.size() == 0) && (m_fifo.size() != 0);
            acc     = i_valid && (m_fifo.size() < DEPTH);
            if (pop_now) begin
                b = m_fifo.pop_front();
                model_frame(b);
            end
            if (acc) begin
                m_fifo.push_back(i_data);
                exp_q.push_back(i_data);
            end
            if (m_line.size() != 0) begin
                m_tx      = m_line.pop_front();
                m_on_line = 1'b1;
            end else begin
                m_tx      = 1'b1;
                m_on_line = 1'b0;
            end
            last_acc = acc;
        end
        #1;
        check("tx", 32'(o_tx), 32'(m_tx));
        check("busy", 32'(o_busy), 32'(m_on_line || (m_fifo.size() != 0)));
        check("ready", 32'(o_ready), 32'(m_fifo.size() < DEPTH));
        check("fifo_count", 32'(o_fifo_count), 32'(m_fifo.size()));
        if (dec_active) begin
            dec_buf.push_back(o_tx);
            if (dec_buf.size() == FRAME) begin
                decode_frame();
                dec_active = 1'b0;
                dec_buf.delete();
            end
        end else if (o_tx === 1'b0) begin
            dec_active = 1'b1;
            dec_buf.push_back(o_tx);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_on_line || m_fifo.size() != 0) && guard < 800) begin
            step();
            guard++;
        end
        check("drain_timeout", 32'(guard < 800), 32'd1);
        repeat (3) step();
    endtask

    initial begin
        int accepted;
        int guard;
        logic saw_not_ready;

        model_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) step();
        check("state_reset", 32'(o_state), 32'd0);
        i_reset = 1'b0;

        // Idle line after reset.
        repeat (50) step();

        // Single byte.
        push_byte(8'hA5);
        repeat (45) step();

        // Back-to-back frames.
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        drain();

        // Hold valid with incrementing data until 0x10..0x14 are accepted.
        i_valid       = 1'b1;
        i_data        = 8'h10;
        accepted      = 0;
        guard         = 0;
        saw_not_ready = 1'b0;
        while (accepted < 5 && guard < 200) begin
            step();
            guard++;
            if (o_ready === 1'b0) saw_not_ready = 1'b1;
            if (last_acc) begin
                accepted++;
                i_data = i_data + 8'd1;
            end
        end
        i_valid = 1'b0;
        check("hold_accepts", 32'(accepted), 32'd5);
        check("ready_dropped", 32'(saw_not_ready), 32'd1);
        drain();

        // Reset in the middle of a frame.
        push_byte(8'h3C);
        repeat (17) step();
        #2;
        i_reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_tx", 32'(o_tx), 32'd1);
        check("rst_async_count", 32'(o_fifo_count), 32'd0);
        check("rst_async_busy", 32'(o_busy), 32'd0);
        repeat (2) step();
        i_reset = 1'b0;
        step();
        push_byte(8'h81);
        drain();

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07);
        drain();
        push_byte(8'h03);
        drain();
`endif

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            i_valid = ($urandom_range(0, 3) == 0);
            i_data  = 8'($urandom);
            step();
        end
        i_valid = 1'b0;
        drain();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
